// File: rtl/divider_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : divider_ctrl_pkg
// Brief  : Shared types and helpers for the even-divider sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package divider_ctrl_pkg;

    localparam int DEFAULT_NW = 32;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DRAIN      = 3'd1,
        LOAD       = 3'd2,
        START      = 3'd3,
        LOCK       = 3'd4,
        RUN        = 3'd5,
        STOP_DRAIN = 3'd6
    } state_t;

    // The divider only supports even ratios of two or more.
    function automatic logic is_valid_n(input logic [63:0] n);
        return (n[0] == 1'b0) && (n >= 64'd2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/divider_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : divider_ctrl_if
// Brief  : Request handshake and divider-side signals of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface divider_ctrl_if #(
    parameter int NW = divider_ctrl_pkg::DEFAULT_NW
);
    logic          req_valid;
    logic          req_ready;
    logic [NW-1:0] req_n;
    logic          stop_req;
    logic          div_out;
    logic          div_enable;
    logic [NW-1:0] div_n;
    logic          locked;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output req_valid, req_n, stop_req, div_out,
        input  req_ready, div_enable, div_n, locked, busy, done, err
    );

    modport slave (
        input  req_valid, req_n, stop_req, div_out,
        output req_ready, div_enable, div_n, locked, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/divider_ctrl_edge_det.sv
`default_nettype none
// ============================================================================
// Module : div_edge_det
// Brief  : Registers the divider output and flags its rising edges.
// Rev    : 1.0  initial release
// ============================================================================
module div_edge_det (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic din,
    output logic      q,
    output logic      rise
);
    logic r_q;
    logic r_q_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q   <= 1'b0;
            r_q_d <= 1'b0;
        end else begin
            r_q   <= din;
            r_q_d <= r_q;
        end
    end

    assign q    = r_q;
    assign rise = r_q & ~r_q_d;
endmodule
`default_nettype wire

// File: rtl/divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module : divider_ctrl
// Brief  : Sequences ratio changes and stops of the even clock divider.
// Config : define LOCK_TIMEOUT_EN to abort a lock that never arrives.
// Rev    : 1.0  initial release
// ============================================================================
module divider_ctrl
    import divider_ctrl_pkg::*;
#(
    parameter int NW         = DEFAULT_NW,
    parameter int DEFAULT_N  = 2,
    parameter int LOCK_EDGES = 2
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    divider_ctrl_if.slave bus
);
    localparam int              c_cnt_w     = (LOCK_EDGES > 1) ? $clog2(LOCK_EDGES) : 1;
    localparam logic [c_cnt_w-1:0] c_last_edge = c_cnt_w'(LOCK_EDGES - 1);

    state_t             r_state;
    logic [NW-1:0]      r_pending_n;
    logic [NW-1:0]      r_div_n;
    logic               r_div_enable;
    logic               r_locked;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [c_cnt_w-1:0] r_lock_cnt;

    logic w_div_out_q;
    logic w_rise;
    logic w_req_ready;
    logic w_xfer;
    logic w_req_ok;
    logic w_timeout;

    div_edge_det u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.div_out),
        .q       (w_div_out_q),
        .rise    (w_rise)
    );

    // A pending stop takes priority, so the handshake is closed that cycle.
    assign w_req_ready = reset_n && ((r_state == IDLE) || (r_state == RUN)) && !bus.stop_req;
    assign w_xfer      = bus.req_valid && w_req_ready;
    assign w_req_ok    = is_valid_n(64'(bus.req_n));

`ifdef LOCK_TIMEOUT_EN
    logic [NW+1:0] r_to_cnt;
    logic [NW+1:0] w_to_limit;

    assign w_to_limit = (NW+2)'(LOCK_EDGES + 1) * {2'b00, r_div_n};
    assign w_timeout  = (r_to_cnt + (NW+2)'(1)) > w_to_limit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state == LOCK) begin
            r_to_cnt <= r_to_cnt + (NW+2)'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_pending_n  <= '0;
            r_div_n      <= NW'(DEFAULT_N);
            r_div_enable <= 1'b0;
            r_locked     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_lock_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_div_enable <= 1'b0;
                    r_locked     <= 1'b0;
                    if (w_xfer) begin
                        if (w_req_ok) begin
                            r_pending_n <= bus.req_n;
                            r_busy      <= 1'b1;
                            r_state     <= LOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_div_enable <= 1'b1;
                    r_locked     <= 1'b1;
                    if (bus.stop_req) begin
                        r_busy  <= 1'b1;
                        r_state <= STOP_DRAIN;
                    end else if (w_xfer) begin
                        if (w_req_ok) begin
                            r_pending_n <= bus.req_n;
                            r_busy      <= 1'b1;
                            r_locked    <= 1'b0;
                            r_state     <= DRAIN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    r_locked <= 1'b0;
                    // Only gate the divider off while its output is low.
                    if (!w_div_out_q) begin
                        r_div_enable <= 1'b0;
                        r_state      <= LOAD;
                    end
                end
                LOAD: begin
                    r_div_enable <= 1'b0;
                    r_div_n      <= r_pending_n;
                    r_state      <= START;
                end
                START: begin
                    r_div_enable <= 1'b1;
                    r_lock_cnt   <= '0;
                    r_state      <= LOCK;
                end
                LOCK: begin
                    if (bus.stop_req) begin
                        r_busy  <= 1'b1;
                        r_state <= STOP_DRAIN;
                    end else if (w_rise && (r_lock_cnt == c_last_edge)) begin
                        r_locked <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= RUN;
                    end else if (w_timeout) begin
                        r_div_enable <= 1'b0;
                        r_locked     <= 1'b0;
                        r_busy       <= 1'b0;
                        r_err        <= 1'b1;
                        r_state      <= IDLE;
                    end else if (w_rise) begin
                        r_lock_cnt <= r_lock_cnt + c_cnt_w'(1);
                    end
                end
                STOP_DRAIN: begin
                    if (!w_div_out_q) begin
                        r_div_enable <= 1'b0;
                        r_locked     <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.div_enable = r_div_enable;
    assign bus.div_n      = r_div_n;
    assign bus.locked     = r_locked;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
endmodule
`default_nettype wire
